operand_mux_pipe: RTL and testbench
===================================

// Module: operand_mux_pipe
// PURPOSE
//  Parametrised successor to the 2:1 operand-B select. Selects operand A and operand B
//  independently from NUM_SRC candidate sources (rs1/rs2 data, immediate, PC, forwarded results).
//  Registers both operands in a one-stage valid/ready pipeline with a 1-entry skid buffer.
//  Sits between decode/register read and the ALU; out_ready stalls never combinationally reach in_ready.
// PARAMETERS
//  WIDTH    32                 operand data width in bits
//  NUM_SRC  4                  number of candidate sources (>=2)
//  SEL_W    $clog2(NUM_SRC)    select width (derived, do not override)
// PORTS
//  clk        in   1              clock; all state updates on rising edge
//  rst        in   1              synchronous, active-high reset
//  in_valid   in   1              upstream has a valid src/select set this cycle
//  in_ready   out  1              block can accept this cycle
//  src_data   in   NUM_SRC*WIDTH  packed sources; source k = src_data[k*WIDTH +: WIDTH]
//  opa_sel    in   SEL_W          source index for operand A
//  opb_sel    in   SEL_W          source index for operand B
//  out_valid  out  1              operand_a/operand_b hold a valid pair
//  out_ready  in   1              downstream (ALU stage) consumes this cycle
//  operand_a  out  WIDTH          registered operand A
//  operand_b  out  WIDTH          registered operand B
//  sel_err    out  1              sticky: an accepted select was >= NUM_SRC
// BEHAVIOUR
//  - accept = in_valid & in_ready; pop = out_valid & out_ready.
//  - Select: sel < NUM_SRC -> source[sel]; sel >= NUM_SRC (non-power-of-2 NUM_SRC) -> all-zero, sets sel_err.
//  - Selection is evaluated on accept. The selected values are captured, not the raw sources.
//  - Storage: main register (drives outputs) + skid entry (skid_valid, skid_a, skid_b).
//  - in_ready = ~skid_valid & ~rst. It depends only on registered state.
//  - Main freed = ~out_valid | pop. When freed:
//      skid_valid: main <= skid; skid <= accepted input if accept, else skid_valid <= 0.
//      else:       main <= selected input if accept; out_valid <= accept.
//  - Main not freed: on accept, skid <= selected input; skid_valid <= 1.
//  - Latency: input accepted at edge N appears on operand_a/b with out_valid=1 after edge N (1 cycle), unless queued behind the skid.
//  - Throughput: 1 pair/cycle when out_ready=1 continuously.
//  - Stall: while out_valid & ~out_ready, operand_a/b/out_valid are held bit-stable.
//  - At most 2 pairs are in flight. The second accepted during a stall fills the skid; in_ready drops the next cycle.
//  - Order is preserved strictly (FIFO). No pair is dropped or duplicated.
//  - Reset (sync, rst=1 at edge): out_valid=0, operand_a=0, operand_b=0, skid_valid=0, sel_err=0.
//    in_ready=0 while rst=1, and 1 on the first cycle after.
//  - Reset mid-stall discards both main and skid contents. A pop presented in the same cycle as rst is ignored.
//  - sel_err is cleared only by rst. Either operand out of range sets it.
// TESTING
//  1 Basic select (NUM_SRC=4): src={0x6,0xFFFFFABC,0x1000,0x2A}, opa=0, opb=1, out_ready=1
//    -> next cycle operand_a=0x6, operand_b=0xFFFFFABC, out_valid=1.
//  2 Back-to-back: 4 pairs with opb_sel=0,1,2,3 on consecutive cycles, out_ready=1
//    -> out 1/cycle, operand_b = 0x6, 0xFFFFFABC, 0x1000, 0x2A in order; in_ready stays 1.
//  3 Stall+skid: out_ready=0, send pairs P1,P2,P3
//    -> P1 in main, P2 in skid, in_ready=0 and P3 held off; outputs stable.
//    -> Raise out_ready: P1, P2, P3 emerge in order, no bubbles after the first.
//  4 Reset mid-stall: main+skid full, assert rst one cycle
//    -> out_valid=0, operands=0, skid_valid=0; in_ready=1 the cycle after rst drops.
//  5 Out-of-range sel (NUM_SRC=3, opb_sel=3) -> operand_b=0, sel_err=1 and stays 1 until rst.
//  6 Random valid/ready (10k cycles) vs scoreboard -> in-order, lossless, no output change while stalled.

Source files
------------

// File: rtl/operand_mux_if.sv
// Operand-select handshake bundle: the upstream src/select set plus the registered operand pair.
// The master drives sources, selects and downstream ready; the slave (the mux pipe) answers.
interface operand_mux_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC)
);
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [SEL_W-1:0]         opa_sel;
  logic [SEL_W-1:0]         opb_sel;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         operand_a;
  logic [WIDTH-1:0]         operand_b;
  logic                     sel_err;

  modport master (
    output in_valid, src_data, opa_sel, opb_sel, out_ready,
    input  in_ready, out_valid, operand_a, operand_b, sel_err
  );

  modport slave (
    input  in_valid, src_data, opa_sel, opb_sel, out_ready,
    output in_ready, out_valid, operand_a, operand_b, sel_err
  );
endinterface

// File: rtl/operand_mux_pipe.sv
// Independent NUM_SRC:1 selection of operands A and B, registered in a one-stage
// valid/ready pipeline with a one-entry skid buffer so out_ready never reaches in_ready.
module operand_mux_pipe #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic           clk,
  input  logic           rst,
  operand_mux_if.slave   bus
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // A producer holds valid and its payload stable until that edge; ready may be
  // asserted without valid. in_ready is derived from registered state only.

  logic [WIDTH-1:0] main_a;
  logic [WIDTH-1:0] main_b;
  logic             main_valid;
  logic [WIDTH-1:0] skid_a;
  logic [WIDTH-1:0] skid_b;
  logic             skid_valid;
  logic             sel_err_q;

  logic [WIDTH-1:0] pick_a;
  logic [WIDTH-1:0] pick_b;
  logic             oor_a;
  logic             oor_b;
  logic             accept;
  logic             pop;
  logic             main_freed;

  // An out-of-range index yields all-zero rather than aliasing onto a real source.
  function automatic logic [WIDTH-1:0] pick_src(
    input logic [NUM_SRC*WIDTH-1:0] src,
    input logic [SEL_W-1:0]         sel
  );
    logic [WIDTH-1:0] val;
    val = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) val = src[k*WIDTH +: WIDTH];
    end
    return val;
  endfunction

  always_comb begin
    pick_a = pick_src(bus.src_data, bus.opa_sel);
    pick_b = pick_src(bus.src_data, bus.opb_sel);
    oor_a  = (int'({1'b0, bus.opa_sel}) >= NUM_SRC);
    oor_b  = (int'({1'b0, bus.opb_sel}) >= NUM_SRC);
  end

  assign bus.in_ready  = ~skid_valid & ~rst;
  assign accept        = bus.in_valid & bus.in_ready;
  assign pop           = main_valid & bus.out_ready;
  assign main_freed    = ~main_valid | pop;

  assign bus.out_valid = main_valid;
  assign bus.operand_a = main_a;
  assign bus.operand_b = main_b;
  assign bus.sel_err   = sel_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_a     <= '0;
      main_b     <= '0;
      main_valid <= 1'b0;
      skid_a     <= '0;
      skid_b     <= '0;
      skid_valid <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      if (accept && (oor_a || oor_b)) sel_err_q <= 1'b1;

      if (main_freed) begin
        if (skid_valid) begin
          // Older pair in the skid moves up first to keep FIFO order.
          main_a     <= skid_a;
          main_b     <= skid_b;
          main_valid <= 1'b1;
          if (accept) begin
            skid_a <= pick_a;
            skid_b <= pick_b;
          end else begin
            skid_valid <= 1'b0;
          end
        end else begin
          if (accept) begin
            main_a <= pick_a;
            main_b <= pick_b;
          end
          main_valid <= accept;
        end
      end else if (accept) begin
        skid_a     <= pick_a;
        skid_b     <= pick_b;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_operand_mux_pipe.sv
// Bench for operand_mux_pipe: directed select/stall/reset cases plus randomized
// valid/ready traffic checked by a queue-based scoreboard against a source-array model.
module tb_operand_mux_pipe;

  localparam int W  = 32;
  localparam int N4 = 4;
  localparam int N3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_mux_if #(.WIDTH(W), .NUM_SRC(N4)) bus4 ();
  operand_mux_if #(.WIDTH(W), .NUM_SRC(N3)) bus3 ();

  operand_mux_pipe #(.WIDTH(W), .NUM_SRC(N4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  operand_mux_pipe #(.WIDTH(W), .NUM_SRC(N3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0]   src4 [N4];
  logic [W-1:0]   src3 [N3];
  logic [2*W-1:0] exp_q [$];
  logic [W-1:0]   b2b_exp [4];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_src4(input logic [W-1:0] s0, input logic [W-1:0] s1,
                          input logic [W-1:0] s2, input logic [W-1:0] s3);
    src4[0] = s0; src4[1] = s1; src4[2] = s2; src4[3] = s3;
    for (int k = 0; k < N4; k++) bus4.src_data[k*W +: W] = src4[k];
  endtask

  task automatic set_src3(input logic [W-1:0] s0, input logic [W-1:0] s1, input logic [W-1:0] s2);
    src3[0] = s0; src3[1] = s1; src3[2] = s2;
    for (int k = 0; k < N3; k++) bus3.src_data[k*W +: W] = src3[k];
  endtask

  // Reference selection: index into the source array, zero when out of range.
  function automatic logic [W-1:0] model4(input int sel);
    return (sel < N4) ? src4[sel] : '0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops before pushing since a pair accepted at the
  // coming edge can never be the one currently on the outputs.
  task automatic monitor();
    logic         prev_stall;
    logic [W-1:0] prev_a;
    logic [W-1:0] prev_b;
    logic [2*W-1:0] e;
    prev_stall = 1'b0;
    prev_a = '0;
    prev_b = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", {31'd0, bus4.out_valid}, 32'd1);
          check("stall_a_held", bus4.operand_a, prev_a);
          check("stall_b_held", bus4.operand_b, prev_b);
        end
        if (bus4.out_valid && bus4.out_ready) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL pop_unexpected: got a=0x%0h b=0x%0h with nothing expected",
                     bus4.operand_a, bus4.operand_b);
          end else begin
            e = exp_q.pop_front();
            check("sb_operand_a", bus4.operand_a, e[2*W-1:W]);
            check("sb_operand_b", bus4.operand_b, e[W-1:0]);
          end
        end
        if (bus4.in_valid && bus4.in_ready)
          exp_q.push_back({model4(int'(bus4.opa_sel)), model4(int'(bus4.opb_sel))});
        prev_stall = bus4.out_valid & ~bus4.out_ready;
        prev_a = bus4.operand_a;
        prev_b = bus4.operand_b;
      end
    end
  endtask

  initial begin
    b2b_exp[0] = 32'h6;
    b2b_exp[1] = 32'hFFFF_FABC;
    b2b_exp[2] = 32'h1000;
    b2b_exp[3] = 32'h2A;

    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.opa_sel = '0; bus4.opb_sel = '0;
    bus3.in_valid = 1'b0; bus3.out_ready = 1'b1; bus3.opa_sel = '0; bus3.opb_sel = '0;
    set_src4(32'h6, 32'hFFFF_FABC, 32'h1000, 32'h2A);
    set_src3(32'h11, 32'h22, 32'h33);
    fork monitor(); join_none

    // Reset state
    step(); step();
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus4.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus4.out_valid}, 32'd0);
    check("rst_operand_a", bus4.operand_a, 32'd0);
    check("rst_operand_b", bus4.operand_b, 32'd0);
    check("rst_sel_err", {31'd0, bus4.sel_err}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, bus4.in_ready}, 32'd1);
    check("post_rst_in_ready3", {31'd0, bus3.in_ready}, 32'd1);
    step();

    // Basic select with one-cycle latency
    bus4.out_ready = 1'b1;
    bus4.opa_sel = 2'd0; bus4.opb_sel = 2'd1; bus4.in_valid = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    @(negedge clk);
    check("basic_out_valid", {31'd0, bus4.out_valid}, 32'd1);
    check("basic_operand_a", bus4.operand_a, 32'h6);
    check("basic_operand_b", bus4.operand_b, 32'hFFFF_FABC);
    step();

    // Back-to-back, one pair per cycle
    for (int i = 0; i < 4; i++) begin
      bus4.opa_sel = 2'($urandom_range(0, 3));
      bus4.opb_sel = 2'(i);
      bus4.in_valid = 1'b1;
      @(negedge clk);
      check("b2b_in_ready", {31'd0, bus4.in_ready}, 32'd1);
      if (i > 0) check("b2b_operand_b", bus4.operand_b, b2b_exp[i-1]);
      step();
    end
    bus4.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_last_operand_b", bus4.operand_b, b2b_exp[3]);
    step();

    // Stall fills main then skid; third pair is held off
    bus4.out_ready = 1'b0;
    bus4.opa_sel = 2'd2; bus4.opb_sel = 2'd3; bus4.in_valid = 1'b1;
    step();
    bus4.opa_sel = 2'd1; bus4.opb_sel = 2'd0;
    step();
    bus4.opa_sel = 2'd3; bus4.opb_sel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready_low", {31'd0, bus4.in_ready}, 32'd0);
      check("stall_p1_a", bus4.operand_a, 32'h1000);
      step();
    end
    bus4.out_ready = 1'b1;
    @(negedge clk);
    check("drain_valid_p1", {31'd0, bus4.out_valid}, 32'd1);
    step();
    @(negedge clk);
    check("drain_valid_p2", {31'd0, bus4.out_valid}, 32'd1);
    check("drain_p2_a", bus4.operand_a, 32'hFFFF_FABC);
    check("drain_in_ready_back", {31'd0, bus4.in_ready}, 32'd1);
    step();
    bus4.in_valid = 1'b0;
    @(negedge clk);
    check("drain_valid_p3", {31'd0, bus4.out_valid}, 32'd1);
    check("drain_p3_b", bus4.operand_b, 32'h1000);
    step();

    // Reset while main and skid are both full
    bus4.out_ready = 1'b0;
    bus4.opa_sel = 2'd1; bus4.opb_sel = 2'd2; bus4.in_valid = 1'b1;
    step();
    bus4.opa_sel = 2'd3; bus4.opb_sel = 2'd0;
    step();
    bus4.in_valid = 1'b0;
    @(negedge clk);
    check("full_in_ready", {31'd0, bus4.in_ready}, 32'd0);
    step();
    rst = 1'b1;
    bus4.out_ready = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", {31'd0, bus4.in_ready}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, bus4.out_valid}, 32'd0);
    check("midrst_operand_a", bus4.operand_a, 32'd0);
    check("midrst_operand_b", bus4.operand_b, 32'd0);
    check("midrst_in_ready_after", {31'd0, bus4.in_ready}, 32'd1);
    step();

    // Out-of-range select on a three-source instance
    bus3.opa_sel = 2'd0; bus3.opb_sel = 2'd3; bus3.in_valid = 1'b1;
    step();
    bus3.in_valid = 1'b0;
    @(negedge clk);
    check("oor_operand_a", bus3.operand_a, 32'h11);
    check("oor_operand_b", bus3.operand_b, 32'd0);
    check("oor_sel_err", {31'd0, bus3.sel_err}, 32'd1);
    step();
    bus3.opa_sel = 2'd1; bus3.opb_sel = 2'd2; bus3.in_valid = 1'b1;
    step();
    bus3.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("oor_sel_err_sticky", {31'd0, bus3.sel_err}, 32'd1);
      step();
    end
    check("inrange_operand_b", bus3.operand_b, 32'h33);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("oor_sel_err_cleared", {31'd0, bus3.sel_err}, 32'd0);
    step();
    bus3.opa_sel = 2'd3; bus3.opb_sel = 2'd1; bus3.in_valid = 1'b1;
    step();
    bus3.in_valid = 1'b0;
    @(negedge clk);
    check("oor_a_operand_a", bus3.operand_a, 32'd0);
    check("oor_a_sel_err", {31'd0, bus3.sel_err}, 32'd1);
    step();

    // Randomized valid/ready traffic
    for (int c = 0; c < 10000; c++) begin
      if (!(bus4.in_valid && !bus4.in_ready)) begin
        bus4.in_valid = ($urandom_range(0, 2) != 0);
        bus4.opa_sel  = 2'($urandom_range(0, 3));
        bus4.opb_sel  = 2'($urandom_range(0, 3));
        set_src4($urandom, $urandom, $urandom, $urandom);
      end
      bus4.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("final_out_valid", {31'd0, bus4.out_valid}, 32'd0);
    check("final_sel_err4", {31'd0, bus4.sel_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
